// File: rtl/mmio_art_key_target_pkg.sv
// mmio_pkg: shared constants, register map and TX state encoding for the ART/KEY responder.
package mmio_pkg;
    localparam logic [63:0] BASE_ADDR_DEF = 64'h8000_0000;
    localparam logic [1:0] REG_ART_TX   = 2'd0;
    localparam logic [1:0] REG_STAT     = 2'd1;
    localparam logic [1:0] REG_KEY_DATA = 2'd2;
    localparam logic [1:0] REG_IRQ_CTRL = 2'd3;
    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_NONEMPTY = 2;
    localparam int ST_IRQ_PENDING = 3;
    localparam int ST_TX_OVF      = 4;
    localparam int ST_RX_OVF      = 5;
    localparam logic [3:0] IRQ_KEY = 4'd1;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
endpackage

// File: rtl/mmio_art_key_target_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO; a pop in the same cycle frees room for a push when full.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_count;
    logic w_push, w_pop;
    assign o_empty = r_count == '0;
    assign o_full = r_count == (AW+1)'(DEPTH);
    assign o_count = r_count;
    assign o_dout = r_mem[r_rd];
    assign w_pop = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_din;
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/mmio_art_key_target.sv
// mmio_art_key_target: bus responder for the UART TX (ART) and keyboard RX (KEY) windows,
// with TX/RX FIFOs, an 8N1 serializer and a key interrupt.
module mmio_art_key_target
    import mmio_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR    = BASE_ADDR_DEF,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          TX_DEPTH     = 16,
    parameter int          RX_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] bus_address,
    input  logic [63:0] bus_write_data,
    input  logic        bus_write_enable,
    input  logic        bus_read_enable,
    output logic [63:0] bus_read_data,
    input  logic        key_valid,
    input  logic [7:0]  key_data,
    output logic        uart_tx,
    output logic [3:0]  interrupt_vector,
    input  logic        interrupt_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    tx_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0] r_idx;
    logic [7:0] r_shift;
    logic r_tx, r_irq, r_irq_en, r_tx_ovf, r_rx_ovf;
    logic [63:0] r_rdata;
    logic w_hit, w_wr, w_rd, w_bit_end;
    logic [1:0] w_reg;
    logic w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic w_rx_pop, w_rx_full, w_rx_empty, w_rx_last;
    logic [7:0] w_tx_dout, w_rx_dout;
    logic [$clog2(TX_DEPTH):0] w_tx_count;
    logic [$clog2(RX_DEPTH):0] w_rx_count;
    logic [63:0] w_stat, w_rmux;
    assign w_hit = bus_address[63:5] == BASE_ADDR[63:5];
    assign w_reg = bus_address[4:3];
    assign w_wr = bus_write_enable & w_hit;
    assign w_rd = bus_read_enable & w_hit;
    assign w_tx_push = w_wr & (w_reg == REG_ART_TX);
    assign w_tx_pop = (r_state == S_IDLE) & ~w_tx_empty;
    assign w_rx_pop = w_rd & (w_reg == REG_KEY_DATA) & ~w_rx_empty;
    // RX drains to empty only if this pop is not refilled by a coincident key
    assign w_rx_last = w_rx_pop & ~key_valid & (w_rx_count == 1);
    assign w_bit_end = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign w_stat = {58'b0, r_rx_ovf, r_tx_ovf, r_irq, ~w_rx_empty, w_tx_empty, w_tx_full};
    assign w_rmux = (w_reg == REG_STAT) ? w_stat :
                    (w_reg == REG_KEY_DATA) ? (w_rx_empty ? 64'd0 : {55'b0, 1'b1, w_rx_dout}) :
                    (w_reg == REG_IRQ_CTRL) ? {63'b0, r_irq_en} : 64'd0;
    assign bus_read_data = r_rdata;
    assign uart_tx = r_tx;
    assign interrupt_vector = r_irq ? IRQ_KEY : 4'd0;
    sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk(clk), .reset(reset), .i_push(w_tx_push), .i_din(bus_write_data[7:0]),
        .i_pop(w_tx_pop), .o_dout(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty),
        .o_count(w_tx_count)
    );
    sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk(clk), .reset(reset), .i_push(key_valid), .i_din(key_data),
        .i_pop(w_rx_pop), .o_dout(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty),
        .o_count(w_rx_count)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_irq <= 1'b0;
            r_irq_en <= 1'b1;
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (bus_read_enable) r_rdata <= w_hit ? w_rmux : 64'd0;
            if (w_wr && w_reg == REG_IRQ_CTRL) r_irq_en <= bus_write_data[0];
            r_tx_ovf <= (w_tx_push & w_tx_full & ~w_tx_pop) |
                        (r_tx_ovf & ~(w_wr & (w_reg == REG_STAT) & bus_write_data[ST_TX_OVF]));
            r_rx_ovf <= (key_valid & w_rx_full & ~w_rx_pop) |
                        (r_rx_ovf & ~(w_wr & (w_reg == REG_STAT) & bus_write_data[ST_RX_OVF]));
            r_irq <= (key_valid & (~w_rx_full | w_rx_pop) & r_irq_en) |
                     (r_irq & ~interrupt_done & ~w_rx_last);
        end
    end
    // Serializer: uart_tx is registered and changes on the edge that enters each bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tx <= 1'b1;
            r_cnt <= '0;
            r_idx <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= (r_state == S_IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
            case (r_state)
                S_IDLE: if (w_tx_pop) begin
                    r_state <= S_START;
                    r_tx <= 1'b0;
                    r_shift <= w_tx_dout;
                end
                S_START: if (w_bit_end) begin
                    r_state <= S_DATA;
                    r_tx <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_idx <= '0;
                end
                S_DATA: if (w_bit_end) begin
                    r_state <= (r_idx == 3'd7) ? S_STOP : S_DATA;
                    r_tx <= (r_idx == 3'd7) ? 1'b1 : r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_idx <= r_idx + 3'd1;
                end
                S_STOP: if (w_bit_end) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
